// File: rtl/cpu_pkg.sv
// Shared constants, opcode map and FSM state encoding for the 8-bit, 4-register core.
package cpu_pkg;

  localparam int WIDTH     = 8;
  localparam int NREGS     = 4;
  localparam int IDX_W     = $clog2(NREGS);
  localparam int MUL_STEPS = WIDTH;
  localparam int CNT_W     = $clog2(MUL_STEPS);
  localparam int SH_W      = $clog2(WIDTH);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_MUL  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Opcodes that finish in one cycle and write a register through the ALU.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the single-cycle opcodes; returns result, carry/borrow and zero.
module exec_alu
  import cpu_pkg::*;
(
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH:0]   wide;
  logic [SH_W-1:0]  sh;

  assign sh = b[SH_W-1:0];

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV: result = b;
      // The extra guard bit catches the last bit shifted out; it stays 0 for a zero shift.
      OP_SHL: begin
        wide   = {1'b0, a} << sh;
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
      end
      OP_SHR: begin
        wide   = {a, 1'b0} >> sh;
        result = wide[WIDTH:1];
        carry  = wide[0];
      end
      default: ;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exec_writeback.sv
// Execute + writeback stage: owns the register file, flags, the shift-add multiplier and the run/halt FSM.
module exec_writeback
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             opcode,
  input  logic [WIDTH-1:0]       in1_val,
  input  logic [WIDTH-1:0]       in2_val,
  input  logic [IDX_W-1:0]       dst_idx,
  output logic [NREGS*WIDTH-1:0] regs,
  output logic                   wb_valid,
  output logic [IDX_W-1:0]       wb_idx,
  output logic [WIDTH-1:0]       wb_data,
  output logic                   flag_z,
  output logic                   flag_c,
  output logic                   illegal,
  output logic                   halted
);

  state_e           state_q;
  logic [WIDTH-1:0] reg_q [NREGS];
  logic             wb_valid_q, flag_z_q, flag_c_q, illegal_q, halted_q;
  logic [IDX_W-1:0] wb_idx_q, mul_dst_q;
  logic [WIDTH-1:0] wb_data_q;
  logic [WIDTH-1:0] mul_a_q, mul_b_q, mul_acc_q, mul_acc_d;
  logic [CNT_W-1:0] mul_cnt_q;
  logic             mul_last;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_z;

  exec_alu u_alu (
    .opcode (opcode),
    .a      (in1_val),
    .b      (in2_val),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  // One shift-add step: the multiplicand shifts left while the multiplier's LSB gates the add.
  assign mul_acc_d = mul_b_q[0] ? (mul_acc_q + mul_a_q) : mul_acc_q;
  assign mul_last  = (mul_cnt_q == CNT_W'(MUL_STEPS - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      illegal_q  <= 1'b0;
      halted_q   <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_acc_q  <= '0;
      mul_cnt_q  <= '0;
      mul_dst_q  <= '0;
      // NOTE: the register file is architecturally visible and must read 0 after reset, so it is reset here.
      for (int i = 0; i < NREGS; i++) reg_q[i] <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (is_alu_op(opcode)) begin
              reg_q[dst_idx] <= alu_res;
              flag_z_q       <= alu_z;
              flag_c_q       <= alu_c;
              wb_valid_q     <= 1'b1;
              wb_idx_q       <= dst_idx;
              wb_data_q      <= alu_res;
            end else if (opcode == OP_MUL) begin
              mul_a_q   <= in1_val;
              mul_b_q   <= in2_val;
              mul_acc_q <= '0;
              mul_cnt_q <= '0;
              mul_dst_q <= dst_idx;
              state_q   <= ST_MUL;
            end else if (opcode == OP_HALT) begin
              halted_q <= 1'b1;
              state_q  <= ST_HALTED;
            end else if (opcode != OP_NOP) begin
              illegal_q <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          mul_acc_q <= mul_acc_d;
          mul_a_q   <= mul_a_q << 1;
          mul_b_q   <= mul_b_q >> 1;
          mul_cnt_q <= mul_cnt_q + 1'b1;
          if (mul_last) begin
            reg_q[mul_dst_q] <= mul_acc_d;
            flag_z_q         <= (mul_acc_d == '0);
            flag_c_q         <= 1'b0;
            wb_valid_q       <= 1'b1;
            wb_idx_q         <= mul_dst_q;
            wb_data_q        <= mul_acc_d;
            state_q          <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_pack
    assign regs[g*WIDTH +: WIDTH] = reg_q[g];
  end

  assign in_ready = (state_q == ST_IDLE);
  assign wb_valid = wb_valid_q;
  assign wb_idx   = wb_idx_q;
  assign wb_data  = wb_data_q;
  assign flag_z   = flag_z_q;
  assign flag_c   = flag_c_q;
  assign illegal  = illegal_q;
  assign halted   = halted_q;

endmodule
